// File: rtl/fp_dot_ctrl.sv
// fp_dot_ctrl: floating-point dot product over a stream of operand pairs.
// It uses one combinational multiplier and one adder with a 1-cycle pipeline stage.
// Two ping-pong partial accumulators hide the adder latency. They are merged at the end of the vector.
// Latency: last pair accepted in cycle t -> out_valid from cycle t+4.
// Backpressure: in_ready only in IDLE/ACCUM; the result is held in DONE until out_ready.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/in_a/in_b/in_last operand stream;
//        out_valid/out_ready/out_data/out_count result stream; busy = not IDLE.
// Optional build macro FP_DOT_CTRL_RELU_EN: negative results are replaced by +0 on writeback.

// mul_fp: combinational sign/exponent/mantissa multiplier, truncating.
// Latency 0. No flow control.
// An operand with exponent 0 is treated as zero. Underflow flushes to 0; overflow gives inf.
module mul_fp #(
  parameter int EXP_BIT  = 8,
  parameter int MAT_BIT  = 7,
  parameter int DATA_BIT = EXP_BIT + MAT_BIT + 1
) (
  input  logic [DATA_BIT-1:0] a_i,
  input  logic [DATA_BIT-1:0] b_i,
  output logic [DATA_BIT-1:0] p_o
);
  localparam int BIAS = (1 << (EXP_BIT - 1)) - 1;
  localparam int EMAX = (1 << EXP_BIT) - 1;

  logic                   sign;
  logic [2*MAT_BIT+1:0]   prod;
  logic [MAT_BIT-1:0]     mant;
  int                     exp_r;
  logic                   unused_lsb;

  always_comb begin
    sign  = a_i[DATA_BIT-1] ^ b_i[DATA_BIT-1];
    prod  = {{(MAT_BIT+1){1'b0}}, 1'b1, a_i[MAT_BIT-1:0]} *
            {{(MAT_BIT+1){1'b0}}, 1'b1, b_i[MAT_BIT-1:0]};
    exp_r = int'(a_i[DATA_BIT-2:MAT_BIT]) + int'(b_i[DATA_BIT-2:MAT_BIT]) - BIAS;
    // Product of two 1.x mantissas lies in [1,4); renormalise when it reaches 2.
    if (prod[2*MAT_BIT+1]) begin
      mant  = prod[2*MAT_BIT:MAT_BIT+1];
      exp_r = exp_r + 1;
    end else begin
      mant  = prod[2*MAT_BIT-1:MAT_BIT];
    end
    if (a_i[DATA_BIT-2:MAT_BIT] == '0 || b_i[DATA_BIT-2:MAT_BIT] == '0 || exp_r <= 0)
      p_o = '0;
    else if (exp_r >= EMAX)
      p_o = {sign, {EXP_BIT{1'b1}}, {MAT_BIT{1'b0}}};
    else
      p_o = {sign, exp_r[EXP_BIT-1:0], mant};
  end

  // Product bits below the kept mantissa are truncated.
  assign unused_lsb = ^prod[MAT_BIT-1:0];
endmodule

// add_fp: floating-point adder with align, add/sub and normalise stages, truncating.
// Latency is 1 cycle when ENABLE_PIPELINE is nonzero, otherwise 0. No flow control.
// A zero operand passes the other through unchanged. Exact cancellation gives +0.
module add_fp #(
  parameter int EXP_BIT         = 8,
  parameter int MAT_BIT         = 7,
  parameter int DATA_BIT        = EXP_BIT + MAT_BIT + 1,
  parameter int ENABLE_PIPELINE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_BIT-1:0] a_i,
  input  logic [DATA_BIT-1:0] b_i,
  output logic [DATA_BIT-1:0] s_o
);
  localparam int GRD  = 3;                  // guard bits kept through alignment
  localparam int MW   = MAT_BIT + 1 + GRD;  // hidden bit + mantissa + guard
  localparam int EMAX = (1 << EXP_BIT) - 1;

  logic [DATA_BIT-1:0] big, sml, sum_d;
  logic [EXP_BIT-1:0]  e_big, shamt;
  logic [MW-1:0]       m_big, m_sml, norm;
  logic [MW:0]         m_sum;
  logic                found;
  int                  lz, e_res;
  logic                unused_grd;

  always_comb begin
    // Order operands by magnitude so the subtraction never goes negative.
    if (a_i[DATA_BIT-2:0] >= b_i[DATA_BIT-2:0]) begin
      big = a_i;
      sml = b_i;
    end else begin
      big = b_i;
      sml = a_i;
    end
    e_big = big[DATA_BIT-2:MAT_BIT];
    shamt = e_big - sml[DATA_BIT-2:MAT_BIT];
    m_big = {1'b1, big[MAT_BIT-1:0], {GRD{1'b0}}};
    m_sml = {1'b1, sml[MAT_BIT-1:0], {GRD{1'b0}}} >> shamt;
    if (big[DATA_BIT-1] == sml[DATA_BIT-1])
      m_sum = {1'b0, m_big} + {1'b0, m_sml};
    else
      m_sum = {1'b0, m_big} - {1'b0, m_sml};

    lz    = 0;
    found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!found) begin
        if (m_sum[i]) found = 1'b1;
        else          lz    = lz + 1;
      end
    end

    if (m_sum[MW]) begin
      norm  = m_sum[MW:1];
      e_res = int'(e_big) + 1;
    end else begin
      norm  = m_sum[MW-1:0] << lz;
      e_res = int'(e_big) - lz;
    end

    if (a_i[DATA_BIT-2:MAT_BIT] == '0)
      sum_d = b_i;
    else if (b_i[DATA_BIT-2:MAT_BIT] == '0)
      sum_d = a_i;
    else if (m_sum == '0 || e_res <= 0)
      sum_d = '0;
    else if (e_res >= EMAX)
      sum_d = {big[DATA_BIT-1], {EXP_BIT{1'b1}}, {MAT_BIT{1'b0}}};
    else
      sum_d = {big[DATA_BIT-1], e_res[EXP_BIT-1:0], norm[MW-2:GRD]};
  end

  assign unused_grd = ^norm[GRD-1:0];

  if (ENABLE_PIPELINE != 0) begin : g_pipe
    logic [DATA_BIT-1:0] sum_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sum_q <= '0;
      else     sum_q <= sum_d;
    end
    assign s_o = sum_q;
  end else begin : g_comb
    assign s_o = sum_d;
  end
endmodule

module fp_dot_ctrl #(
  parameter int EXP_BIT  = 8,
  parameter int MAT_BIT  = 7,
  parameter int DATA_BIT = EXP_BIT + MAT_BIT + 1,
  parameter int CNT_BIT  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_BIT-1:0] in_a,
  input  logic [DATA_BIT-1:0] in_b,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_BIT-1:0] out_data,
  output logic [CNT_BIT-1:0]  out_count,
  output logic                busy
);
  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, MERGE, WB, DONE} state_t;

  state_t              state_q, state_d;
  logic                in_ready_q;
  logic [DATA_BIT-1:0] acc0_q, acc1_q;
  logic                k_q;
  logic [CNT_BIT-1:0]  cnt_q;
  logic                wb_vld_q, wb_idx_q;
  logic [DATA_BIT-1:0] out_data_q;
  logic [CNT_BIT-1:0]  out_count_q;

  logic                accept, clear;
  logic [DATA_BIT-1:0] prod, add_a, add_b, add_sum, res_wb;

  assign accept = in_valid & in_ready_q;

  mul_fp #(.EXP_BIT(EXP_BIT), .MAT_BIT(MAT_BIT), .DATA_BIT(DATA_BIT)) u_mul (
    .a_i(in_a),
    .b_i(in_b),
    .p_o(prod)
  );

  // The adder is shared: accumulate into acc[k] while streaming, and acc0+acc1 in MERGE.
  assign add_a = (state_q == MERGE) ? acc0_q : (k_q ? acc1_q : acc0_q);
  assign add_b = (state_q == MERGE) ? acc1_q : prod;

  add_fp #(.EXP_BIT(EXP_BIT), .MAT_BIT(MAT_BIT), .DATA_BIT(DATA_BIT), .ENABLE_PIPELINE(1)) u_add (
    .clk(clk),
    .rst(~rst_n),
    .a_i(add_a),
    .b_i(add_b),
    .s_o(add_sum)
  );

`ifdef FP_DOT_CTRL_RELU_EN
  assign res_wb = add_sum[DATA_BIT-1] ? '0 : add_sum;
`else
  assign res_wb = add_sum;
`endif

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    case (state_q)
      IDLE, ACCUM: if (accept) state_d = in_last ? DRAIN : ACCUM;
      // The last pair's sum is written back during this cycle.
      DRAIN:       if (wb_vld_q) state_d = MERGE;
      MERGE:       state_d = WB;
      WB:          state_d = DONE;
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          clear   = 1'b1;
        end
      end
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      // Registered so that in_ready stays low while reset is asserted.
      in_ready_q <= (state_d == IDLE) || (state_d == ACCUM);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc0_q      <= '0;
      acc1_q      <= '0;
      k_q         <= 1'b0;
      cnt_q       <= '0;
      wb_vld_q    <= 1'b0;
      wb_idx_q    <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      wb_vld_q <= accept;
      wb_idx_q <= k_q;
      if (clear) begin
        acc0_q <= '0;
        acc1_q <= '0;
        k_q    <= 1'b0;
        cnt_q  <= '0;
      end else begin
        if (wb_vld_q) begin
          if (wb_idx_q) acc1_q <= add_sum;
          else          acc0_q <= add_sum;
        end
        if (accept) begin
          k_q <= ~k_q;
          if (cnt_q != '1) cnt_q <= cnt_q + CNT_BIT'(1);
        end
      end
      if (state_q == WB) begin
        out_data_q  <= res_wb;
        out_count_q <= cnt_q;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == DONE);
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: doc/fp_dot_ctrl.md
# fp_dot_ctrl

Sequencer that computes a floating-point dot product over a streamed vector of operand pairs using one combinational `mul_fp` and one pipelined `add_fp` (`ENABLE_PIPELINE=1`, 1-cycle latency). It hides the adder feedback latency with two ping-pong partial accumulators and merges them at end of vector. It sits between an operand-fetch stream and the result writeback path of a PE row.

## Interface
- `EXP_BIT`, 8, exponent width
- `MAT_BIT`, 7, mantissa width
- `DATA_BIT`, `EXP_BIT+MAT_BIT+1`, operand/result width
- `CNT_BIT`, 16, element-counter width
- `clk` in 1: clock; single clock domain
- `rst_n` in 1: asynchronous, active-low reset; drives the internal `add_fp` reset as `~rst_n`
- `in_valid` in 1: operand pair valid
- `in_ready` out 1: pair accepted when `in_valid && in_ready`
- `in_a` in `DATA_BIT`: operand A
- `in_b` in `DATA_BIT`: operand B
- `in_last` in 1: marks the final pair of the vector
- `out_valid` out 1: result valid
- `out_ready` in 1: result consumed when `out_valid && out_ready`
- `out_data` out `DATA_BIT`: dot-product result
- `out_count` out `CNT_BIT`: number of pairs in the vector; saturates at all-ones
- `busy` out 1: high in every state except IDLE

## Operation
- States: IDLE, ACCUM, DRAIN, MERGE, WB, DONE.
- `in_ready` = 1 in IDLE and ACCUM, 0 otherwise.
- Accumulators `acc0` and `acc1` reset to 0. Pointer `k` resets to 0 and toggles on every accepted pair.
- Accepted pair: `p = mul_fp(in_a, in_b)`. The adder is issued with A=`acc[k]` and B=`p`. Its output is written to `acc[k]` at the end of the following cycle.
- Same-`k` reuse is at least 2 cycles apart, so no hazard exists. Bubbles (`in_valid`=0) do not issue and do not toggle `k`.
- IDLE: accept without last -> ACCUM; accept with last -> DRAIN.
- ACCUM: accept with last -> DRAIN; otherwise stay.
- DRAIN: final writeback completes -> MERGE.
- MERGE: adder is issued with A=`acc0`, B=`acc1` -> WB.
- WB: adder output is captured into `out_data` (through the RELU stage if configured) -> DONE.
- DONE: `out_valid`=1. `out_data` and `out_count` are held stable until `out_ready`. On handshake: go to IDLE and clear `acc0`, `acc1`, `k` and the counter.
- Zero handling is inherited from `mul_fp`/`add_fp`:
  - An operand with exponent 0 gives product 0.
  - A zero accumulator passes the other addend through unchanged.
  - Exact cancellation gives 0x0000.
- Counter: increments on each accepted pair and saturates. It is latched to `out_count` in WB.

## Timing
- Reset values: `in_ready`=0 during reset and 1 in IDLE after release; `out_valid`=0; `out_data`=0; `out_count`=0; `busy`=0; state=IDLE.
- Throughput: one pair per cycle while in IDLE/ACCUM.
- Latency: last pair accepted in cycle t -> DRAIN t+1, MERGE t+2, WB t+3, `out_valid`=1 from t+4.
- Backpressure: `out_ready` is sampled only in DONE. Minimum time from result to the next `in_ready` is 1 cycle after the out handshake.
- `in_valid` is ignored whenever `in_ready`=0. `in_a`, `in_b` and `in_last` are sampled only at handshake.
- `rst_n` low mid-vector clears all state asynchronously, including the `add_fp` pipeline. A partial result is never emitted.

## Configuration
- `FP_DOT_CTRL_RELU_EN` defined: in WB, a result with sign bit 1 is replaced by 0x0000 (all zeros).
- Not defined: the result is passed unmodified, including the sign.

## Test plan
- Basic vector: bf16 A=[0x3F80, 0x4000, 0x4040], B=[0x3F80, 0x3F80, 0x3F80] back-to-back -> `out_data`=0x40C0 (6.0), `out_count`=3, `out_valid` 4 cycles after the last handshake.
- Single element: A=0x4000, B=0x3F00 with `in_last`=1 -> `out_data`=0x3F80, `out_count`=1.
- Cancellation with bubbles: A=[0x3F80, 0xBF80], B=[0x3F80, 0x3F80], 2 idle cycles between pairs -> `out_data`=0x0000.
- RELU: A=0xBF80, B=0x4000 -> `out_data`=0xC000 without `FP_DOT_CTRL_RELU_EN`, 0x0000 with it.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE -> `out_valid`, `out_data` and `out_count` stable, `in_ready`=0; after the handshake, a new vector [0x3F80]·[0x3F80] returns 0x3F80 (accumulators were cleared).
- Reset mid-operation: assert `rst_n`=0 after 2 of 4 pairs -> all outputs at reset values. After release, a fresh vector [0x4040]·[0x3F80] -> 0x4040, `out_count`=1.
